// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states, flag bit positions and op classification for alu_sequencer
package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_SUM  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MULT = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHR  = 4'd8,
    OP_SHL  = 4'd9
  } opcode_t;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_E = 4;
  localparam logic [3:0] OP_LAST = 4'd9;
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction
endpackage

// File: rtl/Alu.sv
// Alu: combinational N-bit datapath exposing every operation on its own result bus
module Alu #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic [N-1:0] sub,
  output logic [N-1:0] mult,
  output logic [N-1:0] div,
  output logic [N-1:0] mod,
  output logic [N-1:0] and_r,
  output logic [N-1:0] or_r,
  output logic [N-1:0] xor_r,
  output logic [N-1:0] shr,
  output logic [N-1:0] shl
);
  assign sum   = a + b;
  assign sub   = a - b;
  assign mult  = a * b;
  assign div   = (b == '0) ? '0 : a / b;
  assign mod   = (b == '0) ? '0 : a % b;
  assign and_r = a & b;
  assign or_r  = a | b;
  assign xor_r = a ^ b;
  assign shr   = a >> b;
  assign shl   = a << b;
endmodule

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational status flags {E,V,C,N,Z} for a selected ALU result
module alu_flag_gen
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] result,
  input  logic         err,
  output logic [4:0]   flags
);
  logic [N:0] sum_ext;
  logic       carry;
  logic       ovf;
  // carry and overflow are rebuilt here because the Alu buses are only N bits wide
  always_comb begin
    sum_ext = {1'b0, a} + {1'b0, b};
    carry   = (op == OP_SUM) ? sum_ext[N] : (op == OP_SUB) ? (a < b) : 1'b0;
    ovf     = (op == OP_SUM) ? (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]) :
              (op == OP_SUB) ? (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]) : 1'b0;
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[N-1];
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
    flags[FLAG_E] = err;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready front-end for Alu with multicycle DIV/MOD; ALU_SEQ_ACCUM_EN adds an accumulator fed back as operand A
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N        = 4,
  parameter int DIV_WAIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
`ifdef ALU_SEQ_ACCUM_EN
  input  logic         in_acc,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [4:0]   out_flags
);
  localparam int CW = (DIV_WAIT > 1) ? $clog2(DIV_WAIT) : 1;
  state_t       state;
  logic [CW-1:0] cnt;
  logic [3:0]   op_q;
  logic [N-1:0] a_q, b_q, a_sel, sel, result;
  logic [N-1:0] r_sum, r_sub, r_mult, r_div, r_mod, r_and, r_or, r_xor, r_shr, r_shl;
  logic         err;
  logic [4:0]   flags;
`ifdef ALU_SEQ_ACCUM_EN
  logic [N-1:0] acc;
  assign a_sel = in_acc ? acc : in_a;
`else
  assign a_sel = in_a;
`endif
  assign in_ready = (state == IDLE);
  assign err      = (op_q > OP_LAST) || (is_multicycle(op_q) && (b_q == '0));
  assign result   = err ? '0 : sel;

  Alu #(.N(N)) u_alu (
    .a(a_q), .b(b_q),
    .sum(r_sum), .sub(r_sub), .mult(r_mult), .div(r_div), .mod(r_mod),
    .and_r(r_and), .or_r(r_or), .xor_r(r_xor), .shr(r_shr), .shl(r_shl)
  );

  alu_flag_gen #(.N(N)) u_flags (
    .op(op_q), .a(a_q), .b(b_q), .result(result), .err(err), .flags(flags)
  );

  // pick the Alu bus named by the latched opcode
  always_comb begin
    sel = '0;
    case (op_q)
      OP_SUM:  sel = r_sum;
      OP_SUB:  sel = r_sub;
      OP_MULT: sel = r_mult;
      OP_DIV:  sel = r_div;
      OP_MOD:  sel = r_mod;
      OP_AND:  sel = r_and;
      OP_OR:   sel = r_or;
      OP_XOR:  sel = r_xor;
      OP_SHR:  sel = r_shr;
      OP_SHL:  sel = r_shl;
      default: sel = '0;
    endcase
  end

  // accept, wait out the divider, then hold the response until it is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
`ifdef ALU_SEQ_ACCUM_EN
      acc        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= in_op;
          a_q   <= a_sel;
          b_q   <= in_b;
          cnt   <= (is_multicycle(in_op) && (in_b != '0)) ? CW'(DIV_WAIT - 1) : '0;
          state <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          out_result <= result;
          out_flags  <= flags;
          out_valid  <= 1'b1;
          state      <= DONE;
        end else begin
          cnt <= cnt - CW'(1);
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
`ifdef ALU_SEQ_ACCUM_EN
          acc       <= out_result;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer (N=4, DIV_WAIT=3)
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_acc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic [4:0] out_flags;
  int checks = 0;
  int errors = 0;

  alu_sequencer #(.N(4), .DIV_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
`ifdef ALU_SEQ_ACCUM_EN
    .in_acc(in_acc),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int exp_lat, input logic [3:0] exp_res, input logic [4:0] exp_fl, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = 4'd5;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, 32'(out_result), 32'(exp_res));
    chk({tag, "_flags"}, 32'(out_flags), 32'(exp_fl));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_op = 4'd0; in_a = 4'd1; in_b = 4'd1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_res"}, 32'(out_result), 32'(exp_res));
      chk({tag, "_hold_flags"}, 32'(out_flags), 32'(exp_fl));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_result", 32'(out_result), 32'd0);
    chk("reset_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("sum_wrap", 4'd0, 4'd7, 4'd9, 1, 4'h0, 5'b00101, 0);
    run_op("sum_ovf",  4'd0, 4'd7, 4'd1, 1, 4'h8, 5'b01010, 0);
    run_op("sub_brw",  4'd1, 4'd3, 4'd5, 1, 4'hE, 5'b00110, 0);
    run_op("div",      4'd3, 4'd13, 4'd4, 3, 4'h3, 5'b00000, 0);
    run_op("mod",      4'd4, 4'd13, 4'd4, 3, 4'h1, 5'b00000, 0);
    run_op("div_zero", 4'd3, 4'd9, 4'd0, 1, 4'h0, 5'b10001, 0);
    run_op("illegal",  4'hF, 4'd3, 4'd2, 1, 4'h0, 5'b10001, 0);
    run_op("mult",     4'd2, 4'd3, 4'd5, 1, 4'hF, 5'b00010, 0);
    run_op("shl",      4'd9, 4'd3, 4'd1, 1, 4'h6, 5'b00000, 0);
    run_op("xor_hold", 4'd7, 4'd5, 4'd3, 1, 4'h6, 5'b00000, 5);
    run_op("or_after", 4'd6, 4'd4, 4'd1, 1, 4'h5, 5'b00000, 0);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd3; in_a = 4'd13; in_b = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_mid_busy", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
`ifdef ALU_SEQ_ACCUM_EN
    chk("rst_mid_acc", 32'(dut.acc), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_op("and_post_rst", 4'd5, 4'hC, 4'hA, 1, 4'h8, 5'b00010, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequencing front-end for the team's existing combinational ALU datapath (module Alu, N-bit, ten parallel result buses).
- Accepts one operation at a time over a valid/ready request port and registers the operands.
- Holds DIV/MOD for a programmable number of cycles, because the divider path is multicycle.
- Selects the requested result, generates status flags, and holds the response until the consumer accepts it.

Parameters:
N, 4, operand/result width; passed to the Alu instance.
DIV_WAIT, 3, cycles spent in EXEC for DIV/MOD; must be at least 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  request ready
in_op  in  4  opcode (see Behaviour)
in_a  in  N  operand A
in_b  in  N  operand B
out_valid  out  1  response valid
out_ready  in  1  response accepted
out_result  out  N  selected result
out_flags  out  5  {E,V,C,N,Z}

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. Asserting rst forces state IDLE and clears out_valid, out_result, out_flags, the operand registers and the wait counter. in_ready=1 while in IDLE.
- Opcodes: 0 SUM, 1 SUB, 2 MULT, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHR, 9 SHL. Codes 10-15 are illegal.
- FSM states: IDLE, EXEC, DONE. Registered outputs only. in_ready=(state==IDLE).
- IDLE: on in_valid&in_ready, latch in_op/in_a/in_b, go to EXEC, load counter.
  - Counter = DIV_WAIT-1 for DIV/MOD with B!=0.
  - Counter = 0 for all other ops.
- EXEC: decrement counter each cycle. When counter==0, register result and flags, set out_valid, go to DONE.
- Latency: accept on edge k; out_valid rises on edge k+1 (single-cycle ops, illegal ops, DIV/MOD with B==0) or on edge k+DIV_WAIT (DIV/MOD with B!=0).
- DONE: out_result/out_flags stay stable while out_valid=1. On out_valid&out_ready, clear out_valid and go to IDLE. in_ready stays 0 until then; no bypass. Minimum issue interval is 3 cycles.
- Result: Alu output bus selected by the latched opcode. Illegal ops and DIV/MOD with B==0 give result 0 and E=1.
- Flags:
  - Z = (result==0).
  - N = result[N-1].
  - C: carry-out of the (N+1)-bit A+B for SUM; borrow (A<B, unsigned) for SUB; 0 otherwise.
  - V: two's-complement overflow for SUM/SUB; 0 otherwise.
  - E: error (illegal op or divide by zero).
  - C/V are computed locally, since Alu exposes only N-bit results.
- Inputs in_a/in_b/in_op are ignored outside the IDLE accept cycle. Changing them mid-EXEC has no effect.
- Reset mid-EXEC or mid-DONE aborts the operation; the pending result is discarded.

Optional Feature:
ALU_SEQ_ACCUM_EN
- With the macro defined:
  - Adds port in_acc (in, 1) and an N-bit accumulator register, reset to 0.
  - The accumulator loads out_result on each out_valid&out_ready.
  - When in_acc=1 at accept, operand A is taken from the accumulator instead of in_a.
- Without the macro: the port and register are absent, and A is always in_a.

Decomposition:
- Package alu_seq_pkg holds:
  - the opcode enum (4-bit);
  - the FSM state enum;
  - flag bit index constants (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3, FLAG_E=4);
  - the function is_multicycle(op).
- Sub-module: alu_flag_gen. Combinational; inputs op, a, b, result, err; outputs 5-bit flags. It is unit-testable on its own.
- Alu is instantiated unchanged.

Test Plan:
- N=4: SUM A=7 B=9 -> out_result=0, flags Z=1 C=1 V=0 N=0 E=0, out_valid one edge after accept.
- SUM A=7 B=1 -> result 8, N=1 V=1 C=0; SUB A=3 B=5 -> result 0xE, N=1 C=1 V=0.
- DIV_WAIT=3: DIV A=13 B=4 -> result 3, out_valid exactly 3 edges after accept, in_ready=0 throughout. MOD A=13 B=4 -> result 1.
- DIV A=9 B=0 -> result 0, E=1, latency 1. Opcode 0xF -> result 0, E=1, Z=1.
- Hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE on the next edge, and the next request is accepted.
- Assert rst during EXEC of DIV -> out_valid=0, in_ready=1 immediately (asynchronous). Accumulator (if enabled) is 0. A subsequent AND A=0xC B=0xA yields 0x8.
